// File: rtl/convertidor_pkg.sv
// Shared definitions for the bidirectional serial/parallel converter:
// word width, PS state encoding and counter width.
package convertidor_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ps_state_t;

endpackage

// File: rtl/ps_serializer.sv
// Parallel-to-serial path: captures a word on request and shifts it out MSB
// first, one bit per clock, with gapless reload at the final-bit edge.
module ps_serializer
    import convertidor_pkg::*;
#(
    parameter int WIDTH = convertidor_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_start,
    input  logic [WIDTH-1:0] p_in,
    output logic             s_out
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    ps_state_t        state, state_n;
    logic [WIDTH-1:0] preg, preg_n;
    logic [CW-1:0]    pcnt, pcnt_n;
    logic             s_out_n;
    logic             load;

    // A load is accepted only from IDLE or on the edge after the LSB has been shown.
    assign load = s_start && ((state == IDLE) || (pcnt == LAST));

    always_comb begin
        state_n = state;
        preg_n  = preg;
        pcnt_n  = pcnt;
        s_out_n = 1'b0;
        if (load) begin
            preg_n  = p_in;
            s_out_n = p_in[WIDTH-1];
            pcnt_n  = CW'(1);
            state_n = SHIFT;
        end else if (state == SHIFT) begin
            if (pcnt != LAST) begin
                // Rotating keeps the next bit to emit at WIDTH-2 each cycle.
                s_out_n = preg[WIDTH-2];
                preg_n  = {preg[WIDTH-2:0], preg[WIDTH-1]};
                pcnt_n  = pcnt + CW'(1);
            end else begin
                pcnt_n  = '0;
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            preg  <= '0;
            pcnt  <= '0;
            s_out <= 1'b0;
        end else begin
            state <= state_n;
            preg  <= preg_n;
            pcnt  <= pcnt_n;
            s_out <= s_out_n;
        end
    end

endmodule

// File: rtl/convertidor_sp_ps.sv
// Bidirectional serial/parallel converter: free-running deserializer framed
// from reset release, plus an independent on-demand serializer.
module convertidor_sp_ps
    import convertidor_pkg::*;
#(
    parameter int WIDTH = convertidor_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] P_IN,
    input  logic             S_START,
    output logic             P_VALID,
    output logic [WIDTH-1:0] P_OUT,
    output logic             S_OUT
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_BIT = SW'(WIDTH - 1);

    // Only WIDTH-1 history bits are kept; the current S_IN completes the word.
    logic [WIDTH-2:0] sreg;
    logic [SW-1:0]    cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sreg    <= '0;
            cnt     <= '0;
            P_OUT   <= '0;
            P_VALID <= 1'b0;
        end else begin
            sreg <= {sreg[WIDTH-3:0], S_IN};
            if (cnt == LAST_BIT) begin
                cnt     <= '0;
                P_OUT   <= {sreg, S_IN};
                P_VALID <= 1'b1;
            end else begin
                cnt     <= cnt + SW'(1);
                P_VALID <= 1'b0;
            end
        end
    end

    ps_serializer #(
        .WIDTH (WIDTH)
    ) u_ps (
        .clk     (CLK),
        .reset   (RESET),
        .s_start (S_START),
        .p_in    (P_IN),
        .s_out   (S_OUT)
    );

endmodule

// File: tb/tb_convertidor_sp_ps.sv
// Self-checking bench for convertidor_sp_ps: reset table plus scoreboarded
// SP words and PS bit streams, including reload, ignored start and reset abort.
module tb_convertidor_sp_ps;

    logic        CLK;
    logic        RESET;
    logic        S_IN;
    logic [31:0] P_IN;
    logic        S_START;
    logic        P_VALID;
    logic [31:0] P_OUT;
    logic        S_OUT;

    convertidor_sp_ps #(.WIDTH(32)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .S_IN    (S_IN),
        .P_IN    (P_IN),
        .S_START (S_START),
        .P_VALID (P_VALID),
        .P_OUT   (P_OUT),
        .S_OUT   (S_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        sin;
        logic        start;
        logic [31:0] pin;
        logic        exp_sout;
        logic        exp_pvalid;
        logic [31:0] exp_pout;
    } vec_t;

    vec_t        tbl [3];
    int          checks   = 0;
    int          failures = 0;
    int          since    = 0;
    logic [31:0] last_word = '0;
    logic [31:0] word_q [$];
    logic        sout_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, step the edge, update expectations, compare.
    task automatic cycle(input logic rst, input logic sin, input logic start, input logic [31:0] pin);
        logic exp_v;
        logic exp_s;
        RESET   = rst;
        S_IN    = sin;
        S_START = start;
        P_IN    = pin;
        @(posedge CLK);
        #1;
        exp_v = 1'b0;
        exp_s = 1'b0;
        if (rst) begin
            since     = 0;
            last_word = '0;
            word_q.delete();
            sout_q.delete();
        end else begin
            since++;
            if (since % 32 == 0) begin
                exp_v = 1'b1;
                if (word_q.size() > 0) last_word = word_q.pop_front();
                else                   last_word = '0;
            end
            if (sout_q.size() > 0) exp_s = sout_q.pop_front();
        end
        check("p_valid", {31'b0, P_VALID}, {31'b0, exp_v});
        check("p_out", P_OUT, last_word);
        check("s_out", {31'b0, S_OUT}, {31'b0, exp_s});
    endtask

    task automatic send_sp_word(input logic [31:0] w);
        word_q.push_back(w);
        for (int i = 31; i >= 0; i--) cycle(1'b0, w[i], 1'b0, $urandom);
    endtask

    task automatic push_ps_bits(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) sout_q.push_back(w[i]);
    endtask

    task automatic ps_load(input logic [31:0] w, input logic sin);
        push_ps_bits(w);
        cycle(1'b0, sin, 1'b1, w);
    endtask

    initial begin
        logic [31:0] w;
        RESET   = 1'b1;
        S_IN    = 1'b0;
        S_START = 1'b0;
        P_IN    = '0;

        tbl[0] = '{rst: 1'b1, sin: 1'b1, start: 1'b1, pin: 32'hFFFF_FFFF, exp_sout: 1'b0, exp_pvalid: 1'b0, exp_pout: 32'h0};
        tbl[1] = '{rst: 1'b1, sin: 1'b1, start: 1'b1, pin: 32'h8000_0001, exp_sout: 1'b0, exp_pvalid: 1'b0, exp_pout: 32'h0};
        tbl[2] = '{rst: 1'b1, sin: 1'b0, start: 1'b1, pin: 32'hA5A5_F00F, exp_sout: 1'b0, exp_pvalid: 1'b0, exp_pout: 32'h0};

        for (int i = 0; i < 3; i++) begin
            cycle(tbl[i].rst, tbl[i].sin, tbl[i].start, tbl[i].pin);
            check("tbl_sout", {31'b0, S_OUT}, {31'b0, tbl[i].exp_sout});
            check("tbl_pvalid", {31'b0, P_VALID}, {31'b0, tbl[i].exp_pvalid});
            check("tbl_pout", P_OUT, tbl[i].exp_pout);
        end

        // SP single word, then two words back-to-back.
        send_sp_word(32'hA5A5_F00F);
        send_sp_word(32'h0000_0001);
        send_sp_word(32'hFFFF_FFFE);

        // PS single word; P_IN wanders after the load.
        ps_load(32'h8000_0001, 1'b0);
        for (int k = 1; k < 32; k++) cycle(1'b0, 1'b0, 1'b0, $urandom);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, $urandom);

        // PS mid-word start ignored, then gapless reload at the final-bit edge.
        ps_load(32'h1234_5678, 1'b0);
        for (int k = 1; k < 32; k++) cycle(1'b0, 1'b0, (k == 10), $urandom);
        ps_load(32'h0000_FFFF, 1'b0);
        for (int k = 1; k < 32; k++) cycle(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset partway through both an SP word and a PS word.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        w = 32'hDEAD_BEEF;
        word_q.push_back(w);
        ps_load(32'hFFFF_FFFF, w[31]);
        for (int i = 1; i < 10; i++) cycle(1'b0, w[31-i], 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        send_sp_word(32'h600D_F00D);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
